// File: rtl/binary_down_counter.sv
// binary_down_counter: loadable down-counter with terminal-count pulse
// and sticky done flag; holds at zero once the count runs out.
// Ports:
//   clk, rst          - rising-edge clock, async active-high reset
//   load, load_value  - capture load_value on this edge (wins over enable)
//   enable            - decrement permission while in RUN
//   count             - current count (registered)
//   busy, tc, done    - in RUN / one-cycle terminal pulse / in DONE
// Option: define BINARY_DOWN_COUNTER_RELOAD_EN for auto-reload, where
// the terminal decrement reloads the last loaded value and stays in RUN.
module binary_down_counter #(
    parameter int size = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [size-1:0] load_value,
    input  logic            enable,
    output logic [size-1:0] count,
    output logic            busy,
    output logic            tc,
    output logic            done
);

    localparam logic [size-1:0] ZERO = '0;
    localparam logic [size-1:0] ONE  = size'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [size-1:0] count_q, count_d;
    logic            busy_q, busy_d;
    logic            tc_q, tc_d;
    logic            done_q, done_d;

`ifdef BINARY_DOWN_COUNTER_RELOAD_EN
    logic [size-1:0] reload_q, reload_d;
`endif

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        tc_d    = 1'b0;
`ifdef BINARY_DOWN_COUNTER_RELOAD_EN
        reload_d = reload_q;
`endif
        if (load) begin
            // A load overrides any decrement, including the terminal one.
            count_d = load_value;
            state_d = (load_value != ZERO) ? RUN : DONE;
`ifdef BINARY_DOWN_COUNTER_RELOAD_EN
            reload_d = load_value;
`endif
        end else if (state_q == RUN && enable) begin
            if (count_q == ONE) begin
                tc_d = 1'b1;
`ifdef BINARY_DOWN_COUNTER_RELOAD_EN
                // reload_q is nonzero here: RUN is only entered via a
                // nonzero load.
                count_d = reload_q;
`else
                count_d = ZERO;
                state_d = DONE;
`endif
            end else begin
                count_d = count_q - ONE;
            end
        end
        // Status flags are registered copies of the next state so the
        // outputs come straight from flops.
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= ZERO;
            busy_q  <= 1'b0;
            tc_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            busy_q  <= busy_d;
            tc_q    <= tc_d;
            done_q  <= done_d;
        end
    end

`ifdef BINARY_DOWN_COUNTER_RELOAD_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reload_q <= ZERO;
        end else begin
            reload_q <= reload_d;
        end
    end
`endif

    assign count = count_q;
    assign busy  = busy_q;
    assign tc    = tc_q;
    assign done  = done_q;

endmodule

// File: tb/tb_binary_down_counter.sv
// tb_binary_down_counter: directed tests for binary_down_counter (size=4).
// Define BINARY_DOWN_COUNTER_RELOAD_EN to exercise the auto-reload build.
module tb_binary_down_counter;

    logic       clk;
    logic       rst;
    logic       load;
    logic [3:0] load_value;
    logic       enable;
    logic [3:0] count;
    logic       busy;
    logic       tc;
    logic       done;

    int tests;
    int fails;

    binary_down_counter #(.size(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .load_value (load_value),
        .enable     (enable),
        .count      (count),
        .busy       (busy),
        .tc         (tc),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle just past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        load = 1'b0;
        load_value = 4'd0;
        enable = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if ({count, busy, tc, done} !== 7'b0) begin
            fails++;
            $display("FAIL reset_hold: got cnt=%0d b=%b t=%b d=%b want 0/0/0/0",
                     count, busy, tc, done);
        end
        rst = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            tests++;
            if ({count, busy, tc, done} !== 7'b0) begin
                fails++;
                $display("FAIL idle_%0d: got cnt=%0d b=%b t=%b d=%b want 0/0/0/0",
                         i, count, busy, tc, done);
            end
        end
    endtask

    task automatic test_oneshot();
        load = 1'b1;
        load_value = 4'd4;
        enable = 1'b1;
        tick();
        load = 1'b0;
        tests++;
        if ({count, busy, tc, done} !== {4'd4, 3'b100}) begin
            fails++;
            $display("FAIL os_load: got cnt=%0d b=%b t=%b d=%b want 4/1/0/0",
                     count, busy, tc, done);
        end
        for (int e = 3; e >= 1; e--) begin
            tick();
            tests++;
            if ({count, busy, tc, done} !== {4'(e), 3'b100}) begin
                fails++;
                $display("FAIL os_dec_%0d: got cnt=%0d b=%b t=%b d=%b want %0d/1/0/0",
                         e, count, busy, tc, done, e);
            end
        end
        tick();
        tests++;
        if ({count, busy, tc, done} !== {4'd0, 3'b011}) begin
            fails++;
            $display("FAIL os_term: got cnt=%0d b=%b t=%b d=%b want 0/0/1/1",
                     count, busy, tc, done);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            tests++;
            if ({count, busy, tc, done} !== {4'd0, 3'b001}) begin
                fails++;
                $display("FAIL os_hold_%0d: got cnt=%0d b=%b t=%b d=%b want 0/0/0/1",
                         i, count, busy, tc, done);
            end
        end
    endtask

    task automatic test_enable_gating();
        load = 1'b1;
        load_value = 4'd5;
        enable = 1'b1;
        tick();
        load = 1'b0;
        tick();
        tick();
        tests++;
        if (count !== 4'd3) begin
            fails++;
            $display("FAIL gate_pre: got cnt=%0d want 3", count);
        end
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if ({count, busy, tc, done} !== {4'd3, 3'b100}) begin
                fails++;
                $display("FAIL gate_hold_%0d: got cnt=%0d b=%b t=%b d=%b want 3/1/0/0",
                         i, count, busy, tc, done);
            end
        end
        enable = 1'b1;
        tick();
        tick();
        tests++;
        if ({count, busy, tc, done} !== {4'd1, 3'b100}) begin
            fails++;
            $display("FAIL gate_one: got cnt=%0d b=%b t=%b d=%b want 1/1/0/0",
                     count, busy, tc, done);
        end
        tick();
        tests++;
        if ({count, busy, tc, done} !== {4'd0, 3'b011}) begin
            fails++;
            $display("FAIL gate_term: got cnt=%0d b=%b t=%b d=%b want 0/0/1/1",
                     count, busy, tc, done);
        end
    endtask

    task automatic test_load_priority();
        load = 1'b1;
        load_value = 4'd2;
        enable = 1'b1;
        tick();
        load = 1'b0;
        tick();
        tests++;
        if (count !== 4'd1) begin
            fails++;
            $display("FAIL prio_pre: got cnt=%0d want 1", count);
        end
        load = 1'b1;
        load_value = 4'd6;
        tick();
        tests++;
        if ({count, busy, tc, done} !== {4'd6, 3'b100}) begin
            fails++;
            $display("FAIL prio_load6: got cnt=%0d b=%b t=%b d=%b want 6/1/0/0",
                     count, busy, tc, done);
        end
        load_value = 4'd0;
        tick();
        load = 1'b0;
        tests++;
        if ({count, busy, tc, done} !== {4'd0, 3'b001}) begin
            fails++;
            $display("FAIL prio_load0: got cnt=%0d b=%b t=%b d=%b want 0/0/0/1",
                     count, busy, tc, done);
        end
        tick();
        tests++;
        if ({count, busy, tc, done} !== {4'd0, 3'b001}) begin
            fails++;
            $display("FAIL prio_done_en: got cnt=%0d b=%b t=%b d=%b want 0/0/0/1",
                     count, busy, tc, done);
        end
    endtask

    task automatic test_full_range();
        int edges;
        load = 1'b1;
        load_value = 4'd15;
        enable = 1'b1;
        tick();
        load = 1'b0;
        edges = 0;
        while (tc !== 1'b1 && edges < 20) begin
            tick();
            edges++;
        end
        tests++;
        if (edges !== 15 || count !== 4'd0) begin
            fails++;
            $display("FAIL full_range: got %0d edges cnt=%0d want 15 edges cnt=0",
                     edges, count);
        end
        tick();
        tests++;
        if ({count, tc, done} !== {4'd0, 2'b01}) begin
            fails++;
            $display("FAIL no_wrap: got cnt=%0d t=%b d=%b want 0/0/1",
                     count, tc, done);
        end
    endtask

    task automatic test_async_reset();
        load = 1'b1;
        load_value = 4'd15;
        enable = 1'b1;
        tick();
        load = 1'b0;
        repeat (6) tick();
        tests++;
        if (count !== 4'd9) begin
            fails++;
            $display("FAIL ar_pre: got cnt=%0d want 9", count);
        end
        #2;
        rst = 1'b1;
        #1;
        tests++;
        if ({count, busy, tc, done} !== 7'b0) begin
            fails++;
            $display("FAIL ar_immediate: got cnt=%0d b=%b t=%b d=%b want 0/0/0/0",
                     count, busy, tc, done);
        end
        #1;
        rst = 1'b0;
        tick();
        tests++;
        if ({count, busy, tc, done} !== 7'b0) begin
            fails++;
            $display("FAIL ar_idle: got cnt=%0d b=%b t=%b d=%b want 0/0/0/0",
                     count, busy, tc, done);
        end
    endtask

    task automatic test_reload();
        logic [3:0] exp_c [5];
        logic       exp_t [5];
        exp_c = '{4'd2, 4'd1, 4'd2, 4'd1, 4'd2};
        exp_t = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        load = 1'b1;
        load_value = 4'd2;
        enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            load = 1'b0;
            tests++;
            if ({count, busy, tc, done} !== {exp_c[i], 1'b1, exp_t[i], 1'b0}) begin
                fails++;
                $display("FAIL reload_%0d: got cnt=%0d b=%b t=%b d=%b want %0d/1/%b/0",
                         i, count, busy, tc, done, exp_c[i], exp_t[i]);
            end
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
`ifdef BINARY_DOWN_COUNTER_RELOAD_EN
        test_load_priority();
        test_reload();
        test_async_reset();
`else
        test_oneshot();
        test_enable_gating();
        test_load_priority();
        test_full_range();
        test_async_reset();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
